// File: rtl/mono_run_ctrl.sv
// Boot/run controller: streams a program into IMEM while holding the core in reset, then gates execution.
// IMEM write lands 1 cycle after byte accept; LD_READY only in LOAD, no stall within LOAD; CORE_EN is Mealy in RUN.
module mono_run_ctrl #(
    parameter int ADDR_W = 8,
    parameter int PC_W   = 64,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD_VALID,
    input  logic [7:0]        LD_DATA,
    input  logic              LD_LAST,
    output logic              LD_READY,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [7:0]        IMEM_WDATA,
    input  logic              CMD_RUN,
    input  logic              CMD_STEP,
    input  logic              CMD_HALT,
    input  logic              CMD_RELOAD,
    input  logic              BRK_EN,
    input  logic [PC_W-1:0]   BRK_ADDR,
    input  logic [PC_W-1:0]   PC,
    output logic              CORE_RSTN,
    output logic              CORE_EN,
    output logic [2:0]        STATE,
    output logic [CNT_W-1:0]  CYCLES,
    output logic [ADDR_W:0]   PROG_LEN
);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_RELEASE = 3'd1,
        S_PAUSED  = 3'd2,
        S_RUN     = 3'd3,
        S_STEP    = 3'd4,
        S_DONE    = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   prog_len;
    logic              first_run;
    logic              accept;
    logic              brk_hit;
    logic              end_hit;
    logic              clr_prog;
    logic              core_en;

    assign accept  = (state == S_LOAD) && LD_VALID;
    // First RUN cycle ignores the breakpoint so a run can resume from the PC it stopped on.
    assign brk_hit = BRK_EN && (PC == BRK_ADDR) && !first_run;
    assign end_hit = PC >= PC_W'(prog_len);

    always_comb begin
        state_nxt = state;
        core_en   = 1'b0;
        clr_prog  = 1'b0;
        case (state)
            S_LOAD: begin
                if (accept) begin
                    if (LD_LAST)
                        state_nxt = S_RELEASE;
                    else if (wr_ptr == '1)
                        state_nxt = S_FAULT;
                end
            end
            S_RELEASE: state_nxt = S_PAUSED;
            S_PAUSED: begin
                if (end_hit) begin
                    state_nxt = S_DONE;
                end else if (CMD_HALT) begin
                    state_nxt = S_PAUSED;
                end else if (CMD_RELOAD) begin
                    state_nxt = S_LOAD;
                    clr_prog  = 1'b1;
                end else if (CMD_STEP) begin
                    state_nxt = S_STEP;
                end else if (CMD_RUN) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                core_en = !(CMD_HALT || brk_hit || end_hit);
                if (end_hit)
                    state_nxt = S_DONE;
                else if (CMD_HALT || brk_hit)
                    state_nxt = S_PAUSED;
            end
            S_STEP: begin
                core_en   = 1'b1;
                state_nxt = end_hit ? S_DONE : S_PAUSED;
            end
            S_DONE, S_FAULT: begin
                if (CMD_RELOAD) begin
                    state_nxt = S_LOAD;
                    clr_prog  = 1'b1;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_LOAD;
            wr_ptr     <= '0;
            prog_len   <= '0;
            IMEM_WE    <= 1'b0;
            IMEM_ADDR  <= '0;
            IMEM_WDATA <= '0;
            CYCLES     <= '0;
            first_run  <= 1'b0;
        end else begin
            state     <= state_nxt;
            IMEM_WE   <= accept;
            first_run <= (state_nxt == S_RUN) && (state != S_RUN);
            if (accept) begin
                IMEM_ADDR  <= wr_ptr;
                IMEM_WDATA <= LD_DATA;
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                prog_len   <= prog_len + (ADDR_W+1)'(1);
            end
            if (clr_prog) begin
                wr_ptr   <= '0;
                prog_len <= '0;
                CYCLES   <= '0;
            end else if (core_en && (CYCLES != '1)) begin
                CYCLES <= CYCLES + CNT_W'(1);
            end
        end
    end

    // The core is only held in reset while the program image may be incomplete.
    assign CORE_RSTN = (state != S_LOAD) && (state != S_FAULT);
    assign LD_READY  = (state == S_LOAD);
    assign CORE_EN   = core_en;
    assign STATE     = state;
    assign PROG_LEN  = prog_len;

endmodule

// File: tb/tb_mono_run_ctrl.sv
// Directed bench for mono_run_ctrl with a PC model that advances by 4 per enabled cycle.
module tb_mono_run_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;

    logic        LD_VALID = 1'b0;
    logic [7:0]  LD_DATA = 8'd0;
    logic        LD_LAST = 1'b0;
    logic        LD_READY;
    logic        IMEM_WE;
    logic [7:0]  IMEM_ADDR;
    logic [7:0]  IMEM_WDATA;
    logic        CMD_RUN = 1'b0, CMD_STEP = 1'b0, CMD_HALT = 1'b0, CMD_RELOAD = 1'b0;
    logic        BRK_EN = 1'b0;
    logic [63:0] BRK_ADDR = 64'd0;
    logic [63:0] pc;
    logic        CORE_RSTN;
    logic        CORE_EN;
    logic [2:0]  STATE;
    logic [31:0] CYCLES;
    logic [8:0]  PROG_LEN;

    logic        ld_valid4 = 1'b0;
    logic [7:0]  ld_data4 = 8'd0;
    logic        ld_last4 = 1'b0;
    logic        ld_ready4;
    logic        imem_we4;
    logic [3:0]  imem_addr4;
    logic [7:0]  imem_wdata4;
    logic        cmd_run4 = 1'b0, cmd_reload4 = 1'b0;
    logic [63:0] zero64 = 64'd0;
    logic        core_rstn4;
    logic        core_en4;
    logic [2:0]  state4;
    logic [31:0] cycles4;
    logic [4:0]  prog_len4;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge CORE_RSTN) begin
        if (!CORE_RSTN) pc <= 64'd0;
        else if (CORE_EN) pc <= pc + 64'd4;
    end

    mono_run_ctrl dut (
        .CLK(CLK), .RST(RST),
        .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_READY(LD_READY),
        .IMEM_WE(IMEM_WE), .IMEM_ADDR(IMEM_ADDR), .IMEM_WDATA(IMEM_WDATA),
        .CMD_RUN(CMD_RUN), .CMD_STEP(CMD_STEP), .CMD_HALT(CMD_HALT), .CMD_RELOAD(CMD_RELOAD),
        .BRK_EN(BRK_EN), .BRK_ADDR(BRK_ADDR), .PC(pc),
        .CORE_RSTN(CORE_RSTN), .CORE_EN(CORE_EN), .STATE(STATE), .CYCLES(CYCLES), .PROG_LEN(PROG_LEN)
    );

    mono_run_ctrl #(.ADDR_W(4)) dut4 (
        .CLK(CLK), .RST(RST),
        .LD_VALID(ld_valid4), .LD_DATA(ld_data4), .LD_LAST(ld_last4), .LD_READY(ld_ready4),
        .IMEM_WE(imem_we4), .IMEM_ADDR(imem_addr4), .IMEM_WDATA(imem_wdata4),
        .CMD_RUN(cmd_run4), .CMD_STEP(1'b0), .CMD_HALT(1'b0), .CMD_RELOAD(cmd_reload4),
        .BRK_EN(1'b0), .BRK_ADDR(zero64), .PC(zero64),
        .CORE_RSTN(core_rstn4), .CORE_EN(core_en4), .STATE(state4), .CYCLES(cycles4), .PROG_LEN(prog_len4)
    );

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic load16();
        for (int i = 0; i < 16; i++) begin
            LD_VALID = 1'b1; LD_DATA = 8'(i); LD_LAST = (i == 15);
            tick();
        end
        LD_VALID = 1'b0; LD_LAST = 1'b0;
        tick();
    endtask

    task automatic pulse_run();
        CMD_RUN = 1'b1; tick(); CMD_RUN = 1'b0;
    endtask

    task automatic pulse_reload();
        CMD_RELOAD = 1'b1; tick(); CMD_RELOAD = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_chk++; if (STATE !== 3'd0) $display("FAIL reset_state got %0d exp 0", STATE); else n_pass++;
        n_chk++; if (LD_READY !== 1'b1) $display("FAIL reset_ld_ready got %b exp 1", LD_READY); else n_pass++;
        n_chk++; if (IMEM_WE !== 1'b0 || IMEM_ADDR !== 8'd0 || IMEM_WDATA !== 8'd0)
            $display("FAIL reset_imem got we=%b addr=%0d data=%0d exp 0/0/0", IMEM_WE, IMEM_ADDR, IMEM_WDATA); else n_pass++;
        n_chk++; if (CORE_RSTN !== 1'b0 || CORE_EN !== 1'b0)
            $display("FAIL reset_core got rstn=%b en=%b exp 0/0", CORE_RSTN, CORE_EN); else n_pass++;
        n_chk++; if (CYCLES !== 32'd0 || PROG_LEN !== 9'd0)
            $display("FAIL reset_counts got cycles=%0d len=%0d exp 0/0", CYCLES, PROG_LEN); else n_pass++;
        @(posedge CLK); #1; RST = 1'b1;
    endtask

    task automatic test_load();
        n_chk++; if (CORE_RSTN !== 1'b0) $display("FAIL load_rstn_pre got %b exp 0", CORE_RSTN); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            LD_VALID = 1'b1; LD_DATA = 8'(i); LD_LAST = (i == 15);
            tick();
            n_chk++; if (IMEM_WE !== 1'b1 || IMEM_ADDR !== 8'(i) || IMEM_WDATA !== 8'(i))
                $display("FAIL load_write[%0d] got we=%b addr=%0d data=%0d exp 1/%0d/%0d", i, IMEM_WE, IMEM_ADDR, IMEM_WDATA, i, i); else n_pass++;
            if (i < 15) begin
                n_chk++; if (STATE !== 3'd0 || CORE_RSTN !== 1'b0)
                    $display("FAIL load_hold[%0d] got state=%0d rstn=%b exp 0/0", i, STATE, CORE_RSTN); else n_pass++;
            end else begin
                n_chk++; if (STATE !== 3'd1 || CORE_RSTN !== 1'b1 || LD_READY !== 1'b0)
                    $display("FAIL load_release got state=%0d rstn=%b rdy=%b exp 1/1/0", STATE, CORE_RSTN, LD_READY); else n_pass++;
            end
        end
        LD_VALID = 1'b0; LD_LAST = 1'b0;
        tick();
        n_chk++; if (STATE !== 3'd2 || IMEM_WE !== 1'b0 || CORE_EN !== 1'b0)
            $display("FAIL load_paused got state=%0d we=%b en=%b exp 2/0/0", STATE, IMEM_WE, CORE_EN); else n_pass++;
        n_chk++; if (PROG_LEN !== 9'd16) $display("FAIL load_prog_len got %0d exp 16", PROG_LEN); else n_pass++;
    endtask

    task automatic test_run();
        int en_cnt = 0;
        int n = 0;
        pulse_run();
        n_chk++; if (STATE !== 3'd3 || CORE_EN !== 1'b1)
            $display("FAIL run_start got state=%0d en=%b exp 3/1", STATE, CORE_EN); else n_pass++;
        while (STATE === 3'd3 && n < 20) begin
            if (CORE_EN === 1'b1) en_cnt++;
            tick(); n++;
        end
        n_chk++; if (STATE !== 3'd5) $display("FAIL run_done_state got %0d exp 5", STATE); else n_pass++;
        n_chk++; if (en_cnt != 4) $display("FAIL run_en_cycles got %0d exp 4", en_cnt); else n_pass++;
        n_chk++; if (CYCLES !== 32'd4 || pc !== 64'd16)
            $display("FAIL run_counts got cycles=%0d pc=%0d exp 4/16", CYCLES, pc); else n_pass++;
        pulse_run();
        n_chk++; if (STATE !== 3'd5 || CORE_EN !== 1'b0)
            $display("FAIL done_ignores_run got state=%0d en=%b exp 5/0", STATE, CORE_EN); else n_pass++;
        pulse_reload();
        n_chk++; if (STATE !== 3'd0 || PROG_LEN !== 9'd0 || CYCLES !== 32'd0 || CORE_RSTN !== 1'b0)
            $display("FAIL done_reload got state=%0d len=%0d cycles=%0d rstn=%b exp 0/0/0/0", STATE, PROG_LEN, CYCLES, CORE_RSTN); else n_pass++;
    endtask

    task automatic test_breakpoint();
        int en_cnt = 0;
        int n = 0;
        load16();
        BRK_EN = 1'b1; BRK_ADDR = 64'd8;
        pulse_run();
        while (STATE === 3'd3 && n < 20) begin
            if (CORE_EN === 1'b1) en_cnt++;
            tick(); n++;
        end
        n_chk++; if (STATE !== 3'd2 || pc !== 64'd8 || CYCLES !== 32'd2 || en_cnt != 2)
            $display("FAIL brk_stop got state=%0d pc=%0d cycles=%0d en=%0d exp 2/8/2/2", STATE, pc, CYCLES, en_cnt); else n_pass++;
        en_cnt = 0; n = 0;
        pulse_run();
        n_chk++; if (CORE_EN !== 1'b1) $display("FAIL brk_resume_en got %b exp 1", CORE_EN); else n_pass++;
        while (STATE === 3'd3 && n < 20) begin
            if (CORE_EN === 1'b1) en_cnt++;
            tick(); n++;
        end
        n_chk++; if (STATE !== 3'd5 || CYCLES !== 32'd4 || en_cnt != 2)
            $display("FAIL brk_resume_done got state=%0d cycles=%0d en=%0d exp 5/4/2", STATE, CYCLES, en_cnt); else n_pass++;
        BRK_EN = 1'b0;
        pulse_reload();
    endtask

    task automatic test_step();
        load16();
        for (int k = 0; k < 3; k++) begin
            CMD_STEP = 1'b1; tick(); CMD_STEP = 1'b0;
            n_chk++; if (STATE !== 3'd4 || CORE_EN !== 1'b1)
                $display("FAIL step_pulse[%0d] got state=%0d en=%b exp 4/1", k, STATE, CORE_EN); else n_pass++;
            tick();
            n_chk++; if (STATE !== 3'd2 || CORE_EN !== 1'b0)
                $display("FAIL step_back[%0d] got state=%0d en=%b exp 2/0", k, STATE, CORE_EN); else n_pass++;
        end
        n_chk++; if (pc !== 64'd12 || CYCLES !== 32'd3)
            $display("FAIL step_totals got pc=%0d cycles=%0d exp 12/3", pc, CYCLES); else n_pass++;
        CMD_HALT = 1'b1; CMD_RUN = 1'b1; CMD_RELOAD = 1'b1; tick();
        CMD_HALT = 1'b0; CMD_RUN = 1'b0; CMD_RELOAD = 1'b0;
        n_chk++; if (STATE !== 3'd2 || PROG_LEN !== 9'd16)
            $display("FAIL halt_priority got state=%0d len=%0d exp 2/16", STATE, PROG_LEN); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        pulse_run();
        n_chk++; if (STATE !== 3'd3) $display("FAIL midrun_pre got %0d exp 3", STATE); else n_pass++;
        #2; RST = 1'b0; #1;
        n_chk++; if (STATE !== 3'd0 || CORE_EN !== 1'b0 || CORE_RSTN !== 1'b0 || LD_READY !== 1'b1)
            $display("FAIL midrun_reset got state=%0d en=%b rstn=%b rdy=%b exp 0/0/0/1", STATE, CORE_EN, CORE_RSTN, LD_READY); else n_pass++;
        n_chk++; if (CYCLES !== 32'd0 || PROG_LEN !== 9'd0)
            $display("FAIL midrun_counts got cycles=%0d len=%0d exp 0/0", CYCLES, PROG_LEN); else n_pass++;
        @(posedge CLK); #1; RST = 1'b1;
    endtask

    task automatic test_reset_mid_load();
        LD_VALID = 1'b1; LD_DATA = 8'hA5;
        tick(); tick();
        n_chk++; if (IMEM_WE !== 1'b1 || IMEM_ADDR !== 8'd1 || IMEM_WDATA !== 8'hA5)
            $display("FAIL midload_pre got we=%b addr=%0d data=%0d exp 1/1/165", IMEM_WE, IMEM_ADDR, IMEM_WDATA); else n_pass++;
        #2; RST = 1'b0; #1;
        n_chk++; if (IMEM_WE !== 1'b0 || IMEM_ADDR !== 8'd0 || IMEM_WDATA !== 8'd0 || PROG_LEN !== 9'd0)
            $display("FAIL midload_reset got we=%b addr=%0d data=%0d len=%0d exp 0/0/0/0", IMEM_WE, IMEM_ADDR, IMEM_WDATA, PROG_LEN); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++; if (IMEM_WE !== 1'b0) $display("FAIL midload_no_write[%0d] got %b exp 0", k, IMEM_WE); else n_pass++;
        end
        LD_VALID = 1'b0;
        RST = 1'b1;
        tick();
    endtask

    task automatic test_fault();
        for (int i = 0; i < 17; i++) begin
            ld_valid4 = 1'b1; ld_data4 = 8'(8'h40 + i); ld_last4 = 1'b0;
            tick();
            if (i < 16) begin
                n_chk++; if (imem_we4 !== 1'b1 || imem_addr4 !== 4'(i) || imem_wdata4 !== 8'(8'h40 + i))
                    $display("FAIL fault_write[%0d] got we=%b addr=%0d data=%0d exp 1/%0d/%0d", i, imem_we4, imem_addr4, imem_wdata4, i, 64 + i); else n_pass++;
            end
            if (i == 14) begin
                n_chk++; if (state4 !== 3'd0) $display("FAIL fault_early got %0d exp 0", state4); else n_pass++;
            end
            if (i == 15) begin
                n_chk++; if (state4 !== 3'd6 || ld_ready4 !== 1'b0 || core_rstn4 !== 1'b0 || prog_len4 !== 5'd16)
                    $display("FAIL fault_enter got state=%0d rdy=%b rstn=%b len=%0d exp 6/0/0/16", state4, ld_ready4, core_rstn4, prog_len4); else n_pass++;
            end
            if (i == 16) begin
                n_chk++; if (imem_we4 !== 1'b0 || state4 !== 3'd6)
                    $display("FAIL fault_17th got we=%b state=%0d exp 0/6", imem_we4, state4); else n_pass++;
            end
        end
        ld_valid4 = 1'b0;
        cmd_run4 = 1'b1; tick(); cmd_run4 = 1'b0;
        n_chk++; if (state4 !== 3'd6 || core_en4 !== 1'b0)
            $display("FAIL fault_ignores_run got state=%0d en=%b exp 6/0", state4, core_en4); else n_pass++;
        cmd_reload4 = 1'b1; tick(); cmd_reload4 = 1'b0;
        n_chk++; if (state4 !== 3'd0 || prog_len4 !== 5'd0 || ld_ready4 !== 1'b1 || cycles4 !== 32'd0)
            $display("FAIL fault_reload got state=%0d len=%0d rdy=%b cycles=%0d exp 0/0/1/0", state4, prog_len4, ld_ready4, cycles4); else n_pass++;
        ld_valid4 = 1'b1; ld_data4 = 8'h77; ld_last4 = 1'b1;
        tick();
        ld_valid4 = 1'b0; ld_last4 = 1'b0;
        n_chk++; if (imem_we4 !== 1'b1 || imem_addr4 !== 4'd0 || imem_wdata4 !== 8'h77 || state4 !== 3'd1)
            $display("FAIL fault_reload_ptr got we=%b addr=%0d data=%0d state=%0d exp 1/0/119/1", imem_we4, imem_addr4, imem_wdata4, state4); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_run();
        test_breakpoint();
        test_step();
        test_reset_mid_run();
        test_reset_mid_load();
        test_fault();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
